// File: rtl/dot_product_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : dot_product_pipe_if
// Brief   : Beat-input and result-output handshake bundle for dot_product_pipe.
// Revision: 1.0 - initial release
// ============================================================================
interface dot_product_pipe_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16
);
  logic [DATA_W*LANES-1:0] row;
  logic [DATA_W*LANES-1:0] column;
  logic                    in_i_stb;
  logic                    in_i_last;
  logic                    in_i_ack;
  logic [ACC_W-1:0]        out;
  logic [CNT_W-1:0]        out_beats;
  logic                    out_overflow;
  logic                    out_o_stb;
  logic                    out_o_ack;

  modport master (
    output row, column, in_i_stb, in_i_last, out_o_ack,
    input  in_i_ack, out, out_beats, out_overflow, out_o_stb
  );

  modport slave (
    input  row, column, in_i_stb, in_i_last, out_o_ack,
    output in_i_ack, out, out_beats, out_overflow, out_o_stb
  );
endinterface
`default_nettype wire

// File: rtl/dot_product_pipe.sv
`default_nettype none
// ============================================================================
// Module  : dot_product_pipe
// Brief   : 3-stage signed inner-product engine (multiply, lane reduce,
//           accumulate) with stb/ack on both sides. Define SATURATE_EN for a
//           clamping accumulator with sticky overflow flag.
// Revision: 1.0 - initial release
// ============================================================================
module dot_product_pipe #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16
) (
  input wire               clk,
  input wire               rst,
  dot_product_pipe_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + $clog2(LANES);

  generate
    if (ACC_W < SUM_W) begin : g_acc_too_narrow
      $error("dot_product_pipe: ACC_W must be >= 2*DATA_W+$clog2(LANES)");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t r_state;
  logic   r_out_stb;

  logic w_accept;
  logic w_first;

  assign bus.in_i_ack = rst & ((r_state == ST_IDLE) | (r_state == ST_ACCUM));
  assign w_accept     = bus.in_i_stb & bus.in_i_ack;
  // Only the beat accepted from IDLE opens a new vector.
  assign w_first      = (r_state == ST_IDLE);

  // Stage 1: lane-wise products
  logic signed [PROD_W-1:0] w_prod [LANES];

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_prod[k] = PROD_W'($signed(bus.row[DATA_W*k +: DATA_W]))
                       * PROD_W'($signed(bus.column[DATA_W*k +: DATA_W]));
    end
  endgenerate

  logic                     r_s1_valid, r_s1_first, r_s1_last;
  logic signed [PROD_W-1:0] r_s1_prod [LANES];
  logic                     r_s2_valid, r_s2_first, r_s2_last;
  logic signed [SUM_W-1:0]  r_s2_sum;
  logic                     r_s3_valid, r_s3_last;
  logic signed [SUM_W-1:0]  w_lane_sum;

  always_comb begin
    w_lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_sum = w_lane_sum + SUM_W'(r_s1_prod[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_first <= w_first;
      r_s1_last  <= bus.in_i_last;
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_prod <= w_prod;
    end
    if (r_s1_valid) begin
      r_s2_sum <= w_lane_sum;
    end
  end

  // Stage 3: accumulate
  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r_acc;
  logic        [CNT_W-1:0] r_beats;
  logic signed [ACC_W-1:0] w_sum_ext;
  logic signed [ACC_W-1:0] w_add;
  logic signed [ACC_W-1:0] w_next_acc;

  assign w_sum_ext = ACC_W'(r_s2_sum);
  assign w_add     = r_acc + w_sum_ext;

`ifdef SATURATE_EN
  logic w_pos_ovf, w_neg_ovf, w_clamp;
  logic r_ovf;

  assign w_pos_ovf  = ~r_acc[ACC_W-1] & ~w_sum_ext[ACC_W-1] &  w_add[ACC_W-1];
  assign w_neg_ovf  =  r_acc[ACC_W-1] &  w_sum_ext[ACC_W-1] & ~w_add[ACC_W-1];
  assign w_clamp    = w_pos_ovf | w_neg_ovf;
  assign w_next_acc = w_pos_ovf ? c_acc_max : (w_neg_ovf ? c_acc_min : w_add);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (r_s2_valid) begin
      r_ovf <= r_s2_first ? 1'b0 : (r_ovf | w_clamp);
    end
  end

  assign bus.out_overflow = r_ovf;
`else
  assign w_next_acc       = w_add;
  assign bus.out_overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc   <= '0;
      r_beats <= '0;
    end else if (r_s2_valid) begin
      if (r_s2_first) begin
        r_acc   <= w_sum_ext;
        r_beats <= CNT_W'(1);
      end else begin
        r_acc <= w_next_acc;
        if (r_beats != {CNT_W{1'b1}}) begin
          r_beats <= r_beats + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_out_stb <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= bus.in_i_last ? ST_DRAIN : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept && bus.in_i_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_s3_valid && r_s3_last) begin
            r_state   <= ST_OUT;
            r_out_stb <= 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.out_o_ack) begin
            r_state   <= ST_IDLE;
            r_out_stb <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_out_stb <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = r_acc;
  assign bus.out_beats = r_beats;
  assign bus.out_o_stb = r_out_stb;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_dot_product_pipe
// Brief   : Directed self-checking bench for dot_product_pipe (40- and 34-bit).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dot_product_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dot_product_pipe_if #(.DATA_W(16), .LANES(4), .ACC_W(40), .CNT_W(16)) bus ();
  dot_product_pipe_if #(.DATA_W(16), .LANES(4), .ACC_W(34), .CNT_W(16)) bus34 ();

  dot_product_pipe #(.DATA_W(16), .LANES(4), .ACC_W(40), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dot_product_pipe #(.DATA_W(16), .LANES(4), .ACC_W(34), .CNT_W(16)) dut34 (
    .clk (clk),
    .rst (rst),
    .bus (bus34)
  );

  function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  task automatic send_beat(input logic [63:0] r, input logic [63:0] c, input logic last);
    int   n;
    logic taken;
    n = 0;
    taken = 1'b0;
    bus.row = r;
    bus.column = c;
    bus.in_i_last = last;
    bus.in_i_stb = 1'b1;
    while (!taken && n < 20) begin
      @(negedge clk);
      taken = bus.in_i_ack;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_i_stb = 1'b0;
    bus.in_i_last = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL send_beat: in_i_ack=0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_o_stb && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (bus.out_o_stb !== 1'b1) begin
      errors++;
      $display("FAIL wait_result: out_o_stb=%b after %0d cycles, required 1", bus.out_o_stb, lat);
    end
  endtask

  task automatic take_result();
    bus.out_o_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.out_o_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_i_ack !== 1'b0)  begin errors++; $display("FAIL reset_ack: got %b required 0", bus.in_i_ack); end
    checks++; if (bus.out_o_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b required 0", bus.out_o_stb); end
    checks++; if (bus.out !== 40'h0)      begin errors++; $display("FAIL reset_out: got %h required 0", bus.out); end
    checks++; if (bus.out_beats !== 16'd0) begin errors++; $display("FAIL reset_beats: got %0d required 0", bus.out_beats); end
    checks++; if (bus.out_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", bus.out_overflow); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_i_ack !== 1'b1)  begin errors++; $display("FAIL reset_release_ack: got %b required 1", bus.in_i_ack); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int lat;
    send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
    wait_result(lat);
    checks++; if (lat != 3)                 begin errors++; $display("FAIL single_latency: got %0d required 3", lat); end
    checks++; if (bus.out !== 40'd70)       begin errors++; $display("FAIL single_out: got %h required %h", bus.out, 40'd70); end
    checks++; if (bus.out_beats !== 16'd1)  begin errors++; $display("FAIL single_beats: got %0d required 1", bus.out_beats); end
    checks++; if (bus.out_overflow !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b required 0", bus.out_overflow); end
    take_result();
    checks++; if (bus.out_o_stb !== 1'b0)   begin errors++; $display("FAIL single_stb_drop: got %b required 0", bus.out_o_stb); end
    checks++; if (bus.out !== 40'd70)       begin errors++; $display("FAIL single_out_hold: got %h required %h", bus.out, 40'd70); end
  endtask

  task automatic test_gaps();
    int lat;
    for (int b = 0; b < 3; b++) begin
      send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), b == 2);
      if (b < 2) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    wait_result(lat);
    checks++; if (bus.out !== 40'd24)      begin errors++; $display("FAIL gaps_out: got %h required %h", bus.out, 40'd24); end
    checks++; if (bus.out_beats !== 16'd3) begin errors++; $display("FAIL gaps_beats: got %0d required 3", bus.out_beats); end
    take_result();
  endtask

  task automatic test_signs();
    int lat;
    send_beat(pack4(-1, -2, -3, -4), pack4(5, 6, 7, 8), 1'b1);
    wait_result(lat);
    checks++; if (bus.out !== 40'hFF_FFFF_FFBA) begin errors++; $display("FAIL signs_neg_out: got %h required ffffffffba", bus.out); end
    take_result();
    send_beat(pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768), 1'b1);
    wait_result(lat);
    checks++; if (bus.out !== 40'h01_0000_0000) begin errors++; $display("FAIL signs_minmin_out: got %h required 0100000000", bus.out); end
    checks++; if (bus.out_beats !== 16'd1)      begin errors++; $display("FAIL signs_beats: got %0d required 1", bus.out_beats); end
    take_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b1);
    wait_result(lat);
    bus.row = pack4(1, 2, 3, 4);
    bus.column = pack4(5, 6, 7, 8);
    bus.in_i_last = 1'b1;
    bus.in_i_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_i_ack !== 1'b0 || bus.out !== 40'd8 || bus.out_o_stb !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: ack=%b out=%h stb=%b required ack=0 out=8 stb=1",
                 i, bus.in_i_ack, bus.out, bus.out_o_stb);
      end
      @(posedge clk);
    end
    #1;
    bus.out_o_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.out_o_ack = 1'b0;
    checks++; if (bus.out_o_stb !== 1'b0) begin errors++; $display("FAIL backpressure_stb_drop: got %b required 0", bus.out_o_stb); end
    checks++; if (bus.in_i_ack !== 1'b1)  begin errors++; $display("FAIL backpressure_ack_return: got %b required 1", bus.in_i_ack); end
    @(posedge clk);
    #1;
    bus.in_i_stb = 1'b0;
    bus.in_i_last = 1'b0;
    wait_result(lat);
    checks++; if (lat != 3)                begin errors++; $display("FAIL b2b_latency: got %0d required 3", lat); end
    checks++; if (bus.out !== 40'd70)      begin errors++; $display("FAIL b2b_out: got %h required %h", bus.out, 40'd70); end
    checks++; if (bus.out_beats !== 16'd1) begin errors++; $display("FAIL b2b_beats: got %0d required 1", bus.out_beats); end
    take_result();
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic seen;
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0);
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0);
    rst = 1'b0;
    bus.row = pack4(1, 1, 1, 1);
    bus.column = pack4(1, 1, 1, 1);
    bus.in_i_stb = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_i_ack !== 1'b0) begin errors++; $display("FAIL midreset_ack: got %b required 0", bus.in_i_ack); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_i_stb = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_o_stb) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_stb: out_o_stb seen=%b required 0", seen); end
    send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
    wait_result(lat);
    checks++; if (bus.out !== 40'd70)      begin errors++; $display("FAIL midreset_out: got %h required %h", bus.out, 40'd70); end
    checks++; if (bus.out_beats !== 16'd1) begin errors++; $display("FAIL midreset_beats: got %0d required 1", bus.out_beats); end
    take_result();
  endtask

  task automatic test_saturate();
    int          lat;
    logic [33:0] exp_out;
    logic        exp_ovf;
`ifdef SATURATE_EN
    exp_out = 34'h1_FFFF_FFFF;
    exp_ovf = 1'b1;
`else
    exp_out = 34'h2_FFF4_000C;
    exp_ovf = 1'b0;
`endif
    checks++; if (bus34.in_i_ack !== 1'b1) begin errors++; $display("FAIL sat_ack_idle: got %b required 1", bus34.in_i_ack); end
    bus34.row = pack4(32767, 32767, 32767, 32767);
    bus34.column = pack4(32767, 32767, 32767, 32767);
    bus34.in_i_last = 1'b0;
    bus34.in_i_stb = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus34.in_i_last = 1'b1;
    @(posedge clk);
    #1;
    bus34.in_i_stb = 1'b0;
    bus34.in_i_last = 1'b0;
    lat = 0;
    while (!bus34.out_o_stb && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (bus34.out_o_stb !== 1'b1)    begin errors++; $display("FAIL sat_stb: got %b required 1", bus34.out_o_stb); end
    checks++; if (bus34.out !== exp_out)       begin errors++; $display("FAIL sat_out: got %h required %h", bus34.out, exp_out); end
    checks++; if (bus34.out_overflow !== exp_ovf) begin errors++; $display("FAIL sat_ovf: got %b required %b", bus34.out_overflow, exp_ovf); end
    checks++; if (bus34.out_beats !== 16'd3)   begin errors++; $display("FAIL sat_beats: got %0d required 3", bus34.out_beats); end
    bus34.out_o_ack = 1'b1;
    @(posedge clk);
    #1;
    bus34.out_o_ack = 1'b0;
  endtask

  initial begin
    bus.row = '0;
    bus.column = '0;
    bus.in_i_stb = 1'b0;
    bus.in_i_last = 1'b0;
    bus.out_o_ack = 1'b0;
    bus34.row = '0;
    bus34.column = '0;
    bus34.in_i_stb = 1'b0;
    bus34.in_i_last = 1'b0;
    bus34.out_o_ack = 1'b0;
    test_reset();
    test_single();
    test_gaps();
    test_signs();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
